// File: rtl/fly_formation_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fly_formation_ctrl
// Brief    : Enemy fly formation owner. It tracks the alive mask and the
//            formation origin, marches the block sideways on frame ticks,
//            reverses and drops at the playfield edges, and retires flies on
//            hit requests. The packed per-fly positions feed the sprite stage.
// Revision : 1.0 - initial release
// ============================================================================
module fly_formation_ctrl #(
  parameter int FLY_COUNT   = 16,
  parameter int COLS        = 8,
  parameter int SPACING_X   = 40,
  parameter int SPACING_Y   = 40,
  parameter int START_X     = 16,
  parameter int START_Y     = 32,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 640,
  parameter int STEP_X      = 4,
  parameter int DROP_Y      = 16,
  parameter int STEP_FRAMES = 4,
  parameter int Y_LIMIT     = 400
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_tick,
  input  logic                         start,
  input  logic                         hit_valid,
  input  logic [$clog2(FLY_COUNT)-1:0] hit_idx,
  output logic [10*FLY_COUNT-1:0]      fly_x_flat,
  output logic [10*FLY_COUNT-1:0]      fly_y_flat,
  output logic [FLY_COUNT-1:0]         fly_alive,
  output logic                         marching,
  output logic                         wave_clear,
  output logic                         landed
);

  localparam int ROWS   = FLY_COUNT / COLS;
  localparam int FCNT_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

  // Horizontal extent of one row including the 32 px sprite, and the
  // vertical distance from the origin to the bottom of the last row.
  localparam logic [9:0] C_SPAN      = 10'((COLS - 1) * SPACING_X + 32);
  localparam logic [9:0] C_ROW_EXT   = 10'((ROWS - 1) * SPACING_Y + 32);
  localparam logic [9:0] C_START_X   = 10'(START_X);
  localparam logic [9:0] C_START_Y   = 10'(START_Y);
  localparam logic [9:0] C_X_MIN     = 10'(X_MIN);
  localparam logic [9:0] C_X_MAX     = 10'(X_MAX);
  localparam logic [9:0] C_STEP_X    = 10'(STEP_X);
  localparam logic [9:0] C_DROP_Y    = 10'(DROP_Y);
  localparam logic [9:0] C_Y_LIMIT   = 10'(Y_LIMIT);
  localparam logic [FCNT_W-1:0] C_FCNT_LAST = FCNT_W'(STEP_FRAMES - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_MARCH = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [9:0]             ox_q, ox_d;
  logic [9:0]             oy_q, oy_d;
  logic                   dir_q, dir_d;        // 0 = moving right
  logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
  logic [FLY_COUNT-1:0]   alive_q, alive_d;
  logic                   wave_clear_q, wave_clear_d;
  logic                   landed_q, landed_d;

  // State register with asynchronous active-low reset to the start grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ox_q         <= C_START_X;
      oy_q         <= C_START_Y;
      dir_q        <= 1'b0;
      fcnt_q       <= '0;
      alive_q      <= '0;
      wave_clear_q <= 1'b0;
      landed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      dir_q        <= dir_d;
      fcnt_q       <= fcnt_d;
      alive_q      <= alive_d;
      wave_clear_q <= wave_clear_d;
      landed_q     <= landed_d;
    end
  end

  // Next-state: hits apply in any state, start launches a wave from IDLE,
  // frame ticks pace the march; wave completion takes priority over landing.
  always_comb begin
    state_d      = state_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    dir_d        = dir_q;
    fcnt_d       = fcnt_q;
    alive_d      = alive_q;
    wave_clear_d = 1'b0;
    landed_d     = 1'b0;

    if (hit_valid && (32'(hit_idx) < 32'(FLY_COUNT))) begin
      alive_d[hit_idx] = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          alive_d = '1;               // start overrides a same-cycle hit
          ox_d    = C_START_X;
          oy_d    = C_START_Y;
          dir_d   = 1'b0;
          fcnt_d  = '0;
          state_d = S_MARCH;
        end
      end
      S_MARCH: begin
        if (frame_tick) begin
          if (fcnt_q < C_FCNT_LAST) begin
            fcnt_d = fcnt_q + 1'b1;
          end else begin
            fcnt_d = '0;
            // A reversal only drops; the origin x holds on that step.
            if (!dir_q) begin
              if (ox_q + C_STEP_X + C_SPAN > C_X_MAX) begin
                dir_d = 1'b1;
                oy_d  = oy_q + C_DROP_Y;
              end else begin
                ox_d = ox_q + C_STEP_X;
              end
            end else begin
              if (ox_q < C_X_MIN + C_STEP_X) begin
                dir_d = 1'b0;
                oy_d  = oy_q + C_DROP_Y;
              end else begin
                ox_d = ox_q - C_STEP_X;
              end
            end
          end
        end
        // The landing drop itself is kept, so the frozen grid shows where
        // the formation touched the line.
        if (alive_d == '0) begin
          wave_clear_d = 1'b1;
          state_d      = S_IDLE;
        end else if (oy_d + C_ROW_EXT >= C_Y_LIMIT) begin
          landed_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-fly positions are pure offsets from the registered origin.
  for (genvar i = 0; i < FLY_COUNT; i++) begin : g_fly
    assign fly_x_flat[i*10 +: 10] = ox_q + 10'((i % COLS) * SPACING_X);
    assign fly_y_flat[i*10 +: 10] = oy_q + 10'((i / COLS) * SPACING_Y);
  end

  assign fly_alive  = alive_q;
  assign marching   = (state_q == S_MARCH);
  assign wave_clear = wave_clear_q;
  assign landed     = landed_q;

endmodule
`default_nettype wire

// File: tb/tb_fly_formation_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fly_formation_ctrl
// Brief    : Directed bench for fly_formation_ctrl with hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fly_formation_ctrl;

  logic         clk;
  logic         rst_n;
  logic         frame_tick;
  logic         start;
  logic         hit_valid;
  logic [3:0]   hit_idx;
  logic [159:0] fly_x_flat;
  logic [159:0] fly_y_flat;
  logic [15:0]  fly_alive;
  logic         marching;
  logic         wave_clear;
  logic         landed;

  int tests;
  int fails;

  fly_formation_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .hit_valid  (hit_valid),
    .hit_idx    (hit_idx),
    .fly_x_flat (fly_x_flat),
    .fly_y_flat (fly_y_flat),
    .fly_alive  (fly_alive),
    .marching   (marching),
    .wave_clear (wave_clear),
    .landed     (landed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic hit(input logic [3:0] idx);
    hit_valid = 1'b1;
    hit_idx   = idx;
    cyc();
    hit_valid = 1'b0;
  endtask

  int  nticks;
  bit  seen;

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; hit_valid = 1'b0; hit_idx = '0;
    cyc(); cyc();
    chk("rst_alive", 32'(fly_alive), 32'h0);
    chk("rst_marching", 32'(marching), 0);
    chk("rst_x0", 32'(fly_x_flat[9:0]), 16);
    chk("rst_y0", 32'(fly_y_flat[9:0]), 32);
    rst_n = 1'b1;
    cyc();

    // Frame ticks in IDLE are ignored.
    ticks(4);
    chk("idle_tick_x0", 32'(fly_x_flat[9:0]), 16);

    start = 1'b1; cyc(); start = 1'b0;
    chk("start_alive", 32'(fly_alive), 32'hFFFF);
    chk("start_marching", 32'(marching), 1);
    chk("start_x9", 32'(fly_x_flat[99:90]), 56);
    chk("start_y9", 32'(fly_y_flat[99:90]), 72);

    // 78 steps right: ox = 16 + 4*78 = 328 (328+4+312 = 644 > 640 next).
    ticks(312);
    chk("t312_x0", 32'(fly_x_flat[9:0]), 328);
    chk("t312_y0", 32'(fly_y_flat[9:0]), 32);
    ticks(4);
    chk("t316_x0", 32'(fly_x_flat[9:0]), 328);
    chk("t316_y0", 32'(fly_y_flat[9:0]), 48);
    ticks(4);
    chk("t320_x0", 32'(fly_x_flat[9:0]), 324);

    // Hits: first clears fly 3, the repeat is a no-op. Every 4-bit index is
    // in range for 16 flies, so no out-of-range value can be driven here.
    hit(4'd3);
    chk("hit3_alive", 32'(fly_alive), 32'hFFF7);
    hit(4'd3);
    chk("hit3_again_alive", 32'(fly_alive), 32'hFFF7);

    for (int i = 0; i < 15; i++) begin
      if (i != 3) hit(4'(i));
    end
    chk("kill15_alive", 32'(fly_alive), 32'h8000);
    chk("kill15_wave_clear", 32'(wave_clear), 0);
    chk("kill15_marching", 32'(marching), 1);
    hit(4'd15);
    chk("kill16_wave_clear", 32'(wave_clear), 1);
    chk("kill16_marching", 32'(marching), 0);
    chk("kill16_alive", 32'(fly_alive), 0);
    cyc();
    chk("wave_clear_one_cycle", 32'(wave_clear), 0);
    ticks(8);
    chk("cleared_x0", 32'(fly_x_flat[9:0]), 324);
    chk("cleared_y0", 32'(fly_y_flat[9:0]), 48);

    // New wave, run to landing. Drops land at oy = 32+16n; the formation
    // bottom (oy+72) first reaches 400 at oy = 336, the 19th drop. Drops
    // happen at steps 79 + 83*(n-1), so drop 19 is step 1573 = tick 6292,
    // taken at the right edge (ox = 328).
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_x0", 32'(fly_x_flat[9:0]), 16);
    hit(4'd5);
    nticks = 0; seen = 1'b0;
    while (!seen && nticks < 7000) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      nticks++;
      if (landed) seen = 1'b1;
      else cyc();
    end
    chk("landed_seen", 32'(seen), 1);
    chk("landed_tick", 32'(nticks), 6292);
    chk("landed_marching", 32'(marching), 0);
    chk("landed_alive", 32'(fly_alive), 32'hFFDF);
    chk("landed_x0", 32'(fly_x_flat[9:0]), 328);
    chk("landed_y0", 32'(fly_y_flat[9:0]), 336);
    cyc();
    chk("landed_one_cycle", 32'(landed), 0);
    ticks(4);
    chk("landed_frozen_y0", 32'(fly_y_flat[9:0]), 336);

    start = 1'b1; cyc(); start = 1'b0;
    chk("relaunch_alive", 32'(fly_alive), 32'hFFFF);
    chk("relaunch_x9", 32'(fly_x_flat[99:90]), 56);
    chk("relaunch_y9", 32'(fly_y_flat[99:90]), 72);

    // Move off the start grid (2 steps -> ox = 24), then reset mid-cycle.
    ticks(8);
    chk("premove_x0", 32'(fly_x_flat[9:0]), 24);
    hit_valid = 1'b1; hit_idx = 4'd0; frame_tick = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_alive", 32'(fly_alive), 0);
    chk("async_rst_marching", 32'(marching), 0);
    chk("async_rst_x0", 32'(fly_x_flat[9:0]), 16);
    chk("async_rst_y9", 32'(fly_y_flat[99:90]), 72);
    hit_valid = 1'b0; frame_tick = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Start and hit together in IDLE: start wins.
    start = 1'b1; hit_valid = 1'b1; hit_idx = 4'd2;
    cyc();
    start = 1'b0; hit_valid = 1'b0;
    chk("start_hit_alive", 32'(fly_alive), 32'hFFFF);
    chk("post_rst_marching", 32'(marching), 1);
    chk("post_rst_x0", 32'(fly_x_flat[9:0]), 16);
    chk("post_rst_y0", 32'(fly_y_flat[9:0]), 32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
